// File: rtl/risc_controller_ws.sv
// risc_controller_ws: multi-cycle RISC CPU controller with memory wait states,
// sticky halt/resume, illegal-opcode flag and a retired-instruction counter.
// Optional macro WS_TIMEOUT_EN: when defined, a memory phase stalled for more
// than WAIT_MAX cycles traps into ERROR and raises the sticky bus_err_o flag.
// When it is undefined, memory phases wait indefinitely and bus_err_o is 0.
//
// Memory handshake: a memory phase (INST_FETCH, operand read in OP_FETCH,
// STO write in STORE) asserts its strobe (rd_o or wr_o) as the request and
// holds both strobe and state until mem_ready_i is sampled high on a rising
// clk_i edge; that edge completes the transfer and the FSM advances.
module risc_controller_ws #(
    parameter int OPCODE_W = 3,
    parameter int WAIT_MAX = 7,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                is_zero_i,
    input  logic                mem_ready_i,
    input  logic                resume_i,
    output logic                sel_o,
    output logic                rd_o,
    output logic                ld_ir_o,
    output logic                halt_o,
    output logic                inc_pc_o,
    output logic                ld_ac_o,
    output logic                ld_pc_o,
    output logic                wr_o,
    output logic                data_e_o,
    output logic                ill_op_o,
    output logic                bus_err_o,
    output logic [CNT_W-1:0]    retired_cnt_o,
    output logic [3:0]          state_o
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8,
        ERROR      = 4'd9
    } state_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_e           state_q;
    logic [CNT_W-1:0] retired_q;
    logic             legal;
    logic [2:0]       op3;
    logic             mem_phase;
    logic             stall;

`ifdef WS_TIMEOUT_EN
    localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);

    logic [WAIT_W-1:0] wait_q;
    logic              bus_err_q;

    assign bus_err_o = bus_err_q;
`else
    // WAIT_MAX only matters when the timeout trap is built in.
    logic [31:0] unused_wait_max;
    assign unused_wait_max = WAIT_MAX;
    assign bus_err_o       = 1'b0;
`endif

    // Opcodes above 7 are illegal; only the low three bits name the operation.
    generate
        if (OPCODE_W > 3) begin : g_wide_op
            assign legal = ~|opcode_i[OPCODE_W-1:3];
        end else begin : g_narrow_op
            assign legal = 1'b1;
        end
    endgenerate

    assign op3           = opcode_i[2:0];
    assign mem_phase     = (state_q == INST_FETCH) ||
                           ((state_q == OP_FETCH) && rd_o) ||
                           ((state_q == STORE) && wr_o);
    assign stall         = mem_phase && !mem_ready_i;
    assign retired_cnt_o = retired_q;
    assign state_o       = state_q;

    // Strobe decode: Moore on state, qualified by opcode (and is_zero for SKZ).
    always_comb begin
        sel_o    = 1'b0;
        rd_o     = 1'b0;
        ld_ir_o  = 1'b0;
        halt_o   = 1'b0;
        inc_pc_o = 1'b0;
        ld_ac_o  = 1'b0;
        ld_pc_o  = 1'b0;
        wr_o     = 1'b0;
        data_e_o = 1'b0;
        ill_op_o = 1'b0;
        case (state_q)
            INST_ADDR: sel_o = 1'b1;
            INST_FETCH: begin
                sel_o = 1'b1;
                rd_o  = 1'b1;
            end
            INST_LOAD: begin
                sel_o   = 1'b1;
                ld_ir_o = 1'b1;
            end
            IDLE: begin
                if (!legal) begin
                    ill_op_o = 1'b1;
                end else if (op3 == OP_HLT) begin
                    halt_o = 1'b1;
                end else if ((op3 == OP_SKZ) && is_zero_i) begin
                    inc_pc_o = 1'b1;
                end
            end
            OP_ADDR: sel_o = 1'b0;
            OP_FETCH: rd_o = legal && (op3 != OP_STO);
            ALU_OP: begin
                ld_ac_o = legal && (op3 >= OP_ADD) && (op3 <= OP_LDA);
                ld_pc_o = legal && (op3 == OP_JMP);
            end
            STORE: begin
                wr_o     = legal && (op3 == OP_STO);
                data_e_o = legal && (op3 == OP_STO);
            end
            HALTED: halt_o = 1'b1;
            ERROR:  halt_o = 1'b1;
            default: sel_o = 1'b1;
        endcase
    end

    // Controller FSM: phase sequencing, wait-state hold/timeout, retire count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INST_ADDR;
            retired_q <= '0;
`ifdef WS_TIMEOUT_EN
            wait_q    <= '0;
            bus_err_q <= 1'b0;
`endif
        end else if (stall) begin
`ifdef WS_TIMEOUT_EN
            if (wait_q == WAIT_LAST) begin
                state_q   <= ERROR;
                bus_err_q <= 1'b1;
                wait_q    <= '0;
            end else begin
                wait_q <= wait_q + WAIT_W'(1);
            end
`endif
        end else begin
`ifdef WS_TIMEOUT_EN
            wait_q <= '0;
`endif
            case (state_q)
                INST_ADDR:  state_q <= INST_FETCH;
                INST_FETCH: state_q <= INST_LOAD;
                INST_LOAD:  state_q <= IDLE;
                IDLE: begin
                    if (legal && (op3 == OP_HLT)) begin
                        state_q   <= HALTED;
                        retired_q <= retired_q + CNT_W'(1);
                    end else begin
                        state_q <= OP_ADDR;
                    end
                end
                OP_ADDR:  state_q <= OP_FETCH;
                OP_FETCH: state_q <= ALU_OP;
                ALU_OP:   state_q <= STORE;
                STORE: begin
                    state_q   <= INST_ADDR;
                    retired_q <= retired_q + CNT_W'(1);
                end
                HALTED: begin
                    if (resume_i) begin
                        state_q <= INST_ADDR;
                    end
                end
                ERROR:   state_q <= ERROR;
                default: state_q <= INST_ADDR;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller_ws.sv
// Bench for risc_controller_ws: randomized instructions with random wait
// states, checked per instruction against strobe counts, latency and the
// retired count derived from the opcode rules.
module tb_risc_controller_ws;

    localparam int OPCODE_W = 4;
    localparam int WAIT_MAX = 7;
    localparam int CNT_W    = 3;

    localparam logic [3:0] ST_INST_ADDR = 4'd0;
    localparam logic [3:0] ST_HALTED    = 4'd8;
    localparam logic [3:0] ST_ERROR     = 4'd9;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [OPCODE_W-1:0] opcode_i = '0;
    logic                is_zero_i = 1'b0;
    logic                mem_ready_i = 1'b1;
    logic                resume_i = 1'b0;
    logic                sel_o, rd_o, ld_ir_o, halt_o, inc_pc_o, ld_ac_o;
    logic                ld_pc_o, wr_o, data_e_o, ill_op_o, bus_err_o;
    logic [CNT_W-1:0]    retired_cnt_o;
    logic [3:0]          state_o;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] ret_model = '0;
    logic [CNT_W-1:0] exp_q[$];

    risc_controller_ws #(
        .OPCODE_W(OPCODE_W),
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .opcode_i     (opcode_i),
        .is_zero_i    (is_zero_i),
        .mem_ready_i  (mem_ready_i),
        .resume_i     (resume_i),
        .sel_o        (sel_o),
        .rd_o         (rd_o),
        .ld_ir_o      (ld_ir_o),
        .halt_o       (halt_o),
        .inc_pc_o     (inc_pc_o),
        .ld_ac_o      (ld_ac_o),
        .ld_pc_o      (ld_pc_o),
        .wr_o         (wr_o),
        .data_e_o     (data_e_o),
        .ill_op_o     (ill_op_o),
        .bus_err_o    (bus_err_o),
        .retired_cnt_o(retired_cnt_o),
        .state_o      (state_o)
    );

    // Clock and watchdog.
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset with a mid-cycle assertion; released on a falling edge.
    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        mem_ready_i = 1'b1;
        resume_i    = 1'b0;
        ret_model   = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        checks++;
        if (sel_o !== 1'b1) begin
            $display("FAIL reset_sel got %b want 1", sel_o);
            errors++;
        end
        checks++;
        if ({rd_o, ld_ir_o, halt_o, inc_pc_o, ld_ac_o, ld_pc_o, wr_o, data_e_o, ill_op_o} !== 9'd0) begin
            $display("FAIL reset_strobes got %b want 0", {rd_o, ld_ir_o, halt_o, inc_pc_o, ld_ac_o, ld_pc_o, wr_o, data_e_o, ill_op_o});
            errors++;
        end
        checks++;
        if (retired_cnt_o !== '0 || bus_err_o !== 1'b0 || state_o !== ST_INST_ADDR) begin
            $display("FAIL reset_regs got cnt=%0d bus_err=%b state=%0d want 0 0 0", retired_cnt_o, bus_err_o, state_o);
            errors++;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One instruction from INST_ADDR; s_if/s_op/s_st are stall cycles in each
    // memory phase (ignored when that phase does not touch memory).
    task automatic run_instr(input logic [3:0] op, input logic z, input int s_if,
                             input int s_op, input int s_st, input string tag);
        logic pat[$];
        logic [2:0] o3;
        logic [CNT_W-1:0] exp_cnt;
        bit legal, hlt, reads, stores;
        int n_sel = 0, n_rd = 0, n_ldir = 0, n_halt = 0, n_inc = 0;
        int n_ldac = 0, n_ldpc = 0, n_wr = 0, n_de = 0, n_ill = 0;
        int e_rd, e_wr;
        o3     = op[2:0];
        legal  = (op < 4'd8);
        hlt    = legal && (o3 == 3'd0);
        reads  = legal && !hlt && (o3 != 3'd6);
        stores = legal && (o3 == 3'd6);
        pat.push_back(1'($urandom_range(0, 1)));
        repeat (s_if) pat.push_back(1'b0);
        pat.push_back(1'b1);
        pat.push_back(1'($urandom_range(0, 1)));
        pat.push_back(1'($urandom_range(0, 1)));
        if (!hlt) begin
            pat.push_back(1'($urandom_range(0, 1)));
            if (reads) begin
                repeat (s_op) pat.push_back(1'b0);
                pat.push_back(1'b1);
            end else begin
                pat.push_back(1'($urandom_range(0, 1)));
            end
            pat.push_back(1'($urandom_range(0, 1)));
            if (stores) begin
                repeat (s_st) pat.push_back(1'b0);
                pat.push_back(1'b1);
            end else begin
                pat.push_back(1'($urandom_range(0, 1)));
            end
        end
        e_rd = (s_if + 1) + (reads ? s_op + 1 : 0);
        e_wr = stores ? s_st + 1 : 0;
        opcode_i  = op;
        is_zero_i = z;
        for (int k = 0; k < pat.size(); k++) begin
            mem_ready_i = pat[k];
            resume_i    = (k == pat.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (k == 0) begin
                checks++;
                if (sel_o !== 1'b1 || rd_o !== 1'b0 || ld_ir_o !== 1'b0) begin
                    $display("FAIL %s start sel/rd/ld_ir got %b%b%b want 100", tag, sel_o, rd_o, ld_ir_o);
                    errors++;
                end
            end
            n_sel  += sel_o ? 1 : 0;
            n_rd   += rd_o ? 1 : 0;
            n_ldir += ld_ir_o ? 1 : 0;
            n_halt += halt_o ? 1 : 0;
            n_inc  += inc_pc_o ? 1 : 0;
            n_ldac += ld_ac_o ? 1 : 0;
            n_ldpc += ld_pc_o ? 1 : 0;
            n_wr   += wr_o ? 1 : 0;
            n_de   += data_e_o ? 1 : 0;
            n_ill  += ill_op_o ? 1 : 0;
            @(negedge clk_i);
        end
        #1;
        checks++;
        if (n_rd !== e_rd || n_sel !== 3 + s_if || n_ldir !== 1) begin
            $display("FAIL %s fetch rd=%0d sel=%0d ld_ir=%0d want %0d %0d 1", tag, n_rd, n_sel, n_ldir, e_rd, 3 + s_if);
            errors++;
        end
        checks++;
        if (n_ldac !== ((legal && o3 >= 3'd2 && o3 <= 3'd5) ? 1 : 0) || n_ldpc !== ((legal && o3 == 3'd7) ? 1 : 0)) begin
            $display("FAIL %s exec ld_ac=%0d ld_pc=%0d", tag, n_ldac, n_ldpc);
            errors++;
        end
        checks++;
        if (n_wr !== e_wr || n_de !== e_wr) begin
            $display("FAIL %s store wr=%0d data_e=%0d want %0d", tag, n_wr, n_de, e_wr);
            errors++;
        end
        checks++;
        if (n_inc !== ((legal && o3 == 3'd1 && z) ? 1 : 0) || n_ill !== (legal ? 0 : 1) || n_halt !== (hlt ? 1 : 0)) begin
            $display("FAIL %s idle inc_pc=%0d ill_op=%0d halt=%0d", tag, n_inc, n_ill, n_halt);
            errors++;
        end
        checks++;
        if (hlt) begin
            if (halt_o !== 1'b1 || state_o !== ST_HALTED) begin
                $display("FAIL %s end halt=%b state=%0d want 1 %0d", tag, halt_o, state_o, ST_HALTED);
                errors++;
            end
        end else if (sel_o !== 1'b1 || rd_o !== 1'b0 || state_o !== ST_INST_ADDR) begin
            $display("FAIL %s end sel=%b rd=%b state=%0d want 1 0 0", tag, sel_o, rd_o, state_o);
            errors++;
        end
        ret_model = ret_model + CNT_W'(1);
        exp_q.push_back(ret_model);
        exp_cnt = exp_q.pop_front();
        checks++;
        if (retired_cnt_o !== exp_cnt || bus_err_o !== 1'b0) begin
            $display("FAIL %s retired got %0d want %0d bus_err=%b", tag, retired_cnt_o, exp_cnt, bus_err_o);
            errors++;
        end
    endtask

    task automatic test_basic_ops();
        run_instr(4'd5, 1'b0, 0, 3, 0, "lda_stall3");
        run_instr(4'd2, 1'b1, 0, 0, 0, "add");
        run_instr(4'd6, 1'b0, 2, 0, 4, "sto_stall");
        run_instr(4'd7, 1'b0, 1, 1, 0, "jmp");
        run_instr(4'd1, 1'b1, 0, 0, 0, "skz_zero");
        run_instr(4'd1, 1'b0, 0, 0, 0, "skz_nonzero");
        run_instr(4'hC, 1'b0, 0, 0, 0, "illegal_c");
        run_instr(4'h8, 1'b1, 1, 2, 2, "illegal_8");
    endtask

    task automatic test_halt();
        run_instr(4'd0, 1'b0, 1, 0, 0, "hlt");
        for (int k = 0; k < 5; k++) begin
            resume_i    = 1'b0;
            mem_ready_i = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (halt_o !== 1'b1 || retired_cnt_o !== ret_model) begin
                $display("FAIL halt_hold halt=%b cnt=%0d want 1 %0d", halt_o, retired_cnt_o, ret_model);
                errors++;
            end
            @(negedge clk_i);
        end
        resume_i = 1'b1;
        @(negedge clk_i);
        resume_i = 1'b0;
        #1;
        checks++;
        if (state_o !== ST_INST_ADDR || halt_o !== 1'b0 || retired_cnt_o !== ret_model) begin
            $display("FAIL halt_resume state=%0d halt=%b cnt=%0d want 0 0 %0d", state_o, halt_o, retired_cnt_o, ret_model);
            errors++;
        end
    endtask

    task automatic test_reset_mid_store();
        opcode_i  = 4'd6;
        is_zero_i = 1'b0;
        resume_i  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            mem_ready_i = (k >= 7) ? 1'b0 : 1'b1;
            #1;
            if (k == 8) begin
                checks++;
                if (wr_o !== 1'b1 || data_e_o !== 1'b1) begin
                    $display("FAIL mid_store wr=%b data_e=%b want 1 1", wr_o, data_e_o);
                    errors++;
                end
            end
            @(negedge clk_i);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (sel_o !== 1'b1 || wr_o !== 1'b0 || retired_cnt_o !== '0 || state_o !== ST_INST_ADDR) begin
            $display("FAIL reset_mid_store sel=%b wr=%b cnt=%0d state=%0d want 1 0 0 0", sel_o, wr_o, retired_cnt_o, state_o);
            errors++;
        end
        @(negedge clk_i);
        rst_ni      = 1'b1;
        mem_ready_i = 1'b1;
        ret_model   = '0;
        exp_q.delete();
        run_instr(4'd3, 1'b0, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd0) op = 4'd4;
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 5), "random");
        end
    endtask

`ifdef WS_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        opcode_i = 4'd2;
        for (int k = 0; k < 9; k++) begin
            mem_ready_i = 1'b0;
            #1;
            if (k == 8) begin
                checks++;
                if (rd_o !== 1'b1 || bus_err_o !== 1'b0) begin
                    $display("FAIL timeout_last_stall rd=%b bus_err=%b want 1 0", rd_o, bus_err_o);
                    errors++;
                end
            end
            @(negedge clk_i);
        end
        for (int k = 0; k < 4; k++) begin
            mem_ready_i = 1'b1;
            resume_i    = 1'b1;
            #1;
            checks++;
            if (state_o !== ST_ERROR || bus_err_o !== 1'b1 || halt_o !== 1'b1) begin
                $display("FAIL timeout_error state=%0d bus_err=%b halt=%b want %0d 1 1", state_o, bus_err_o, halt_o, ST_ERROR);
                errors++;
            end
            @(negedge clk_i);
        end
        resume_i = 1'b0;
        do_reset();
        #1;
        checks++;
        if (bus_err_o !== 1'b0 || state_o !== ST_INST_ADDR) begin
            $display("FAIL timeout_reset bus_err=%b state=%0d want 0 0", bus_err_o, state_o);
            errors++;
        end
        run_instr(4'd5, 1'b0, 7, 7, 0, "ready_on_last_stall");
        run_instr(4'd6, 1'b0, 0, 0, 7, "sto_ready_on_last_stall");
    endtask
`else
    task automatic test_timeout();
        run_instr(4'd5, 1'b0, 12, 10, 0, "long_stall_lda");
        run_instr(4'd6, 1'b0, 9, 0, 15, "long_stall_sto");
    endtask
`endif

    initial begin
        test_reset();
        test_basic_ops();
        test_halt();
        test_random();
        test_reset_mid_store();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_controller_ws.md
Name: risc_controller_ws

Overview:
Parametrised successor to the 8-phase RISC CPU controller. It sequences fetch / decode / execute / store phases and holds in any memory phase until the memory handshakes. It adds a sticky halt with resume, a bus-error trap on timeout, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register opcode field, the accumulator zero flag and the memory/datapath enables.

Parameters:
OPCODE_W, 3, opcode field width; must be >= 3. Values 0..7 are legal; any higher value is illegal.
WAIT_MAX, 7, maximum stall cycles allowed in one memory phase before the bus-error trap.
CNT_W, 16, width of retired_cnt.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  OPCODE_W  current instruction opcode from the IR
is_zero  input  1  accumulator zero flag
mem_ready  input  1  memory handshake: completes the current rd/wr phase
resume  input  1  leave HALTED; ignored in every other state
sel  output  1  address mux select: 1 = PC, 0 = IR operand
rd  output  1  memory read strobe
ld_ir  output  1  load instruction register
halt  output  1  CPU halted (HALTED or ERROR)
inc_pc  output  1  increment PC (SKZ skip)
ld_ac  output  1  load accumulator
ld_pc  output  1  load PC (JMP)
wr  output  1  memory write strobe
data_e  output  1  drive data bus from accumulator
ill_op  output  1  one-cycle pulse in IDLE when the opcode is illegal
bus_err  output  1  sticky bus-error flag
retired_cnt  output  CNT_W  number of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- Illegal opcodes execute as NOP: no inc_pc, ld_ac, ld_pc, wr or data_e.
- States, 4-bit encoding: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED, ERROR.
- Reset (rst=0, asynchronous) forces:
  - state = INST_ADDR, wait_cnt = 0, retired_cnt = 0, bus_err = 0;
  - outputs: sel=1, all other strobes 0, ill_op=0, halt=0.
- Strobe outputs are Moore/combinational from state and opcode:
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, ld_ir=1.
  - IDLE:
    - HLT: halt=1.
    - SKZ with is_zero=1: inc_pc=1.
    - Illegal opcode: ill_op=1.
  - OP_ADDR: sel=0.
  - OP_FETCH: rd=1 unless opcode is STO or illegal.
  - ALU_OP: ld_ac=1 for opcodes 2..5; ld_pc=1 for opcode 7.
  - STORE: wr=1 and data_e=1 for STO.
  - HALTED: halt=1.
  - ERROR: halt=1.
- Transitions:
  - INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE.
  - IDLE -> HALTED if HLT, otherwise OP_ADDR.
  - OP_ADDR -> OP_FETCH -> ALU_OP -> STORE -> INST_ADDR.
  - HALTED -> INST_ADDR when resume=1.
  - ERROR is left only by reset.
- Memory phase = INST_FETCH, OP_FETCH with rd=1, or STORE with wr=1.
  - Advance only when mem_ready=1; otherwise hold, strobes stay asserted, and wait_cnt increments.
  - Non-memory OP_FETCH/STORE advance unconditionally; mem_ready is ignored.
- wait_cnt is cleared on every state change and is sized to hold WAIT_MAX.
- Timeout: in a memory phase with wait_cnt == WAIT_MAX and mem_ready=0, go to ERROR next edge and set bus_err=1 (sticky).
  - mem_ready=1 in that same cycle wins: normal advance, no error.
- retired_cnt increments by 1 on the edge STORE -> INST_ADDR and on the edge IDLE -> HALTED; it wraps at all-ones -> 0.
- Zero-wait instruction latency: 8 cycles; each stall cycle adds 1.
- Reset asserted mid-stall or in ERROR returns immediately to the reset state.

Optional Feature:
Macro WS_TIMEOUT_EN.
- Defined: timeout / ERROR / bus_err behave as above.
- Undefined: memory phases wait indefinitely, ERROR is unreachable, bus_err is tied to 0, and the wait_cnt logic is removed.

Test Plan:
1. Reset low mid-STORE with wr=1; release; mem_ready held at 1 -> sel=1, wr=0, retired_cnt=0, and the next instruction fetch starts at INST_ADDR.
2. LDA (5), mem_ready=0 for 3 cycles in OP_FETCH, then 1 -> rd held high 4 cycles, ld_ac=1 one cycle later, instruction takes 11 cycles, retired_cnt +1.
3. HLT (0) -> halt=1 in IDLE, state HALTED; resume pulse 5 cycles later -> INST_ADDR next edge; retired_cnt +1 exactly once.
4. WS_TIMEOUT_EN defined, WAIT_MAX=7, mem_ready stuck 0 in INST_FETCH -> after 8 stall cycles state ERROR, bus_err=1 and halt=1 until reset; a variant raising mem_ready on the 8th stall cycle advances with no error.
5. OPCODE_W=4, opcode=4'hC -> ill_op pulse 1 cycle in IDLE, no ld_ac/ld_pc/wr, retired_cnt +1.
6. SKZ with is_zero=1 then is_zero=0 -> inc_pc=1 for one IDLE cycle only in the first case; CNT_W=2 with 5 instructions retired -> retired_cnt=1.
